// File: rtl/axi_gran_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_gran_pkg
// Description : Shared types and width helpers for the AXI granular
//               transaction tracker (slot status struct, occupancy and
//               age width functions).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_gran_pkg;

  // Per-slot status reported by each slot to the tracker top.
  typedef struct packed {
    logic valid;  // slot holds a live transaction
    logic match;  // slot is the oldest (age 0) live transaction of cnt_id_i
    logic fin;    // the presented delta would exhaust the remaining beats
    logic err;    // matched-slot error view (sticky flag OR same-cycle set)
  } slot_status_t;

  // Width needed to count 0..n valid slots.
  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of the per-slot age and slot index; never narrower than one bit.
  function automatic int age_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_gran_txn_tracker_slot.sv
`default_nettype none
// ============================================================================
// Module      : axi_gran_txn_tracker_slot
// Description : One tracking slot: valid, id, remaining beats, per-ID age and
//               (optionally) a sticky error flag, plus its update logic.
//               Sticky error tracking exists only when
//               AXI_GRAN_TRACKER_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_gran_txn_tracker_slot
  import axi_gran_pkg::*;
#(
  parameter int IdWidth    = 4,
  parameter int LenWidth   = 8,
  parameter int DeltaWidth = LenWidth + 1,
  parameter int AgeWidth   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  alloc_i,      // this slot is filled this cycle
  input  logic [IdWidth-1:0]    alloc_id_i,
  input  logic [LenWidth-1:0]   alloc_len_i,
  input  logic [AgeWidth-1:0]   alloc_age_i,
  input  logic [IdWidth-1:0]    cnt_id_i,
  input  logic [DeltaWidth-1:0] cnt_delta_i,
  input  logic                  dec_i,        // count handshake with decrement
  input  logic                  set_err_i,    // count handshake with set_err
  input  logic                  free_i,       // some slot of cnt_id_i frees now
  output slot_status_t          status_o,
  output logic [IdWidth-1:0]    id_o,
  output logic [LenWidth:0]     rem_o
);

  localparam int RemW = LenWidth + 1;
  localparam int CmpW = (DeltaWidth > RemW) ? DeltaWidth : RemW;

  logic                valid_q, valid_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic [RemW-1:0]     rem_q, rem_d;
  logic [AgeWidth-1:0] age_q, age_d;

  logic [CmpW-1:0] rem_ext;
  logic [CmpW-1:0] delta_ext;
  logic            match;
  logic            fin;
  logic            hit_dec;
  logic            same_id;

  assign rem_ext   = CmpW'(rem_q);
  assign delta_ext = CmpW'(cnt_delta_i);
  assign same_id   = valid_q & (id_q == cnt_id_i);
  assign match     = same_id & (age_q == '0);
  assign fin       = valid_q & (delta_ext >= rem_ext);
  assign hit_dec   = dec_i & match;

  // Next-state: flush, fill, decrement/free, or age-down behind a freed peer.
  always_comb begin
    valid_d = valid_q;
    id_d    = id_q;
    rem_d   = rem_q;
    age_d   = age_q;
    if (flush_i) begin
      valid_d = 1'b0;
      rem_d   = '0;
      age_d   = '0;
    end else if (alloc_i) begin
      valid_d = 1'b1;
      id_d    = alloc_id_i;
      rem_d   = {1'b0, alloc_len_i} + RemW'(1);
      age_d   = alloc_age_i;
    end else if (hit_dec) begin
      if (fin) begin
        valid_d = 1'b0;
        rem_d   = '0;
        age_d   = '0;
      end else begin
        rem_d = RemW'(rem_ext - delta_ext);
      end
    end else if (free_i && same_id && (age_q != '0)) begin
      age_d = age_q - AgeWidth'(1);
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      rem_q   <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      rem_q   <= rem_d;
      age_q   <= age_d;
    end
  end

`ifdef AXI_GRAN_TRACKER_ERR_EN
  logic err_q, err_d;

  // Sticky error: set by a matched set_err handshake, cleared on free/refill.
  always_comb begin
    err_d = err_q;
    if (flush_i || alloc_i) begin
      err_d = 1'b0;
    end else if (hit_dec && fin) begin
      err_d = 1'b0;
    end else if (set_err_i && match) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign status_o.err = match & (err_q | set_err_i);
`else
  logic unused_set_err;
  assign unused_set_err = set_err_i;
  assign status_o.err   = 1'b0;
`endif

  assign status_o.valid = valid_q;
  assign status_o.match = match;
  assign status_o.fin   = fin;
  assign id_o           = id_q;
  assign rem_o          = rem_q;

endmodule
`default_nettype wire

// File: rtl/axi_gran_txn_tracker.sv
`default_nettype none
// ============================================================================
// Module      : axi_gran_txn_tracker
// Description : Tracks up to MaxTxns outstanding AXI bursts. Transactions of
//               the same ID are served in allocation order via a per-slot age;
//               the count port decrements the oldest one and frees it on its
//               final beat. Optional sticky per-slot errors are built when
//               AXI_GRAN_TRACKER_ERR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_gran_txn_tracker
  import axi_gran_pkg::*;
#(
  parameter int MaxTxns    = 4,
  parameter int IdWidth    = 4,
  parameter int LenWidth   = 8,
  parameter int DeltaWidth = LenWidth + 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [IdWidth-1:0]           alloc_id_i,
  input  logic [LenWidth-1:0]          alloc_len_i,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  input  logic [IdWidth-1:0]           cnt_id_i,
  input  logic [DeltaWidth-1:0]        cnt_delta_i,
  input  logic                         cnt_dec_i,
  input  logic                         cnt_set_err_i,
  input  logic                         cnt_valid_i,
  output logic                         cnt_ready_o,
  output logic [LenWidth-1:0]          cnt_len_o,
  output logic                         cnt_last_o,
  output logic                         cnt_err_o,
  output logic                         busy_o,
  output logic [$clog2(MaxTxns+1)-1:0] occupancy_o
);

  localparam int OccW = occ_width(MaxTxns);
  localparam int AgeW = age_width(MaxTxns);
  localparam int IdxW = AgeW;
  localparam int RemW = LenWidth + 1;

  slot_status_t       slot_status [MaxTxns];
  logic [IdWidth-1:0] slot_id     [MaxTxns];
  logic [RemW-1:0]    slot_rem    [MaxTxns];

  logic [MaxTxns-1:0] valid_vec;
  logic [MaxTxns-1:0] match_vec;
  logic [MaxTxns-1:0] fin_vec;
  logic [MaxTxns-1:0] err_vec;
  logic [MaxTxns-1:0] free_mask;
  logic [MaxTxns-1:0] alloc_sel;

  logic [IdxW-1:0] free_idx;
  logic            free_found;
  logic            any_match;
  logic            alloc_hs;
  logic            cnt_hs;
  logic            free_evt;
  logic            freed_same;
  logic [OccW-1:0] same_cnt;
  logic [OccW-1:0] occ;
  logic [AgeW-1:0] alloc_age;
  logic [RemW-1:0] rem_m;

  assign free_mask = ~valid_vec;
  assign any_match = |match_vec;

  // Lowest-index free slot via a trailing-zero count over the free mask.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < MaxTxns; i++) begin
      if (!free_found && free_mask[i]) begin
        free_idx   = IdxW'(i);
        free_found = 1'b1;
      end
    end
  end

  assign alloc_ready_o = ~flush_i & free_found;
  assign alloc_hs      = alloc_valid_i & alloc_ready_o;
  assign cnt_ready_o   = ~flush_i & any_match;
  assign cnt_hs        = cnt_valid_i & cnt_ready_o;
  assign free_evt      = cnt_hs & cnt_dec_i & (|(match_vec & fin_vec));
  assign freed_same    = free_evt & (cnt_id_i == alloc_id_i);

  // Same-ID population, occupancy and matched-slot remaining-beats mux.
  always_comb begin
    same_cnt = '0;
    occ      = '0;
    rem_m    = '0;
    for (int i = 0; i < MaxTxns; i++) begin
      if (valid_vec[i] && (slot_id[i] == alloc_id_i)) begin
        same_cnt = same_cnt + OccW'(1);
      end
      occ = occ + OccW'(valid_vec[i]);
      if (match_vec[i]) begin
        rem_m = rem_m | slot_rem[i];
      end
    end
  end

  // A same-ID slot freeing this cycle moves the newcomer one place forward.
  assign alloc_age = AgeW'(same_cnt - OccW'(freed_same));

  assign cnt_len_o   = any_match ? LenWidth'(rem_m - RemW'(1)) : '0;
  assign cnt_last_o  = free_evt;
  assign cnt_err_o   = |err_vec;
  assign busy_o      = |valid_vec;
  assign occupancy_o = occ;

  for (genvar i = 0; i < MaxTxns; i++) begin : g_slot
    assign alloc_sel[i] = alloc_hs & (free_idx == IdxW'(i));

    axi_gran_txn_tracker_slot #(
      .IdWidth    (IdWidth),
      .LenWidth   (LenWidth),
      .DeltaWidth (DeltaWidth),
      .AgeWidth   (AgeW)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .alloc_i     (alloc_sel[i]),
      .alloc_id_i  (alloc_id_i),
      .alloc_len_i (alloc_len_i),
      .alloc_age_i (alloc_age),
      .cnt_id_i    (cnt_id_i),
      .cnt_delta_i (cnt_delta_i),
      .dec_i       (cnt_hs & cnt_dec_i),
      .set_err_i   (cnt_hs & cnt_set_err_i),
      .free_i      (free_evt),
      .status_o    (slot_status[i]),
      .id_o        (slot_id[i]),
      .rem_o       (slot_rem[i])
    );

    assign valid_vec[i] = slot_status[i].valid;
    assign match_vec[i] = slot_status[i].match;
    assign fin_vec[i]   = slot_status[i].fin;
    assign err_vec[i]   = slot_status[i].err;
  end

endmodule
`default_nettype wire
